// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams parallel config words onto a configuration flip-flop chain and returns the chain's prior contents as readback words
module ccff_chain_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 41
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);
    localparam int RW = $clog2(CHAIN_LEN + 1);
    localparam int CW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] sr, sr_n, rb_sr, rb_sr_n, rb_data_n, rb_word;
    logic [RW-1:0]     rem, rem_n;
    logic [CW-1:0]     cnt, cnt_n, pad, pad_n, take;
    logic              cfg_ready_n, head_n, en_n, rb_valid_n, busy_n, done_n;

    assign take    = (32'(rem) >= WORD_W) ? CW'(WORD_W) : CW'(rem);
    assign rb_word = {rb_sr[WORD_W-2:0], ccff_tail};

    // next-state logic; every output is computed one cycle ahead so it can be registered
    always_comb begin
        state_n     = state;
        sr_n        = sr;
        rb_sr_n     = rb_sr;
        rem_n       = rem;
        cnt_n       = cnt;
        pad_n       = pad;
        rb_data_n   = rb_data;
        cfg_ready_n = 1'b0;
        head_n      = 1'b0;
        en_n        = 1'b0;
        rb_valid_n  = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n     = LOAD;
                rem_n       = RW'(CHAIN_LEN);
                cfg_ready_n = 1'b1;
            end
            LOAD: if (cfg_valid && cfg_ready) begin
                state_n = SHIFT;
                head_n  = cfg_data[WORD_W-1];
                sr_n    = cfg_data << 1;
                en_n    = 1'b1;
                cnt_n   = take;
                pad_n   = CW'(WORD_W) - take;
                rb_sr_n = '0;
            end else begin
                cfg_ready_n = 1'b1;
            end
            SHIFT: begin
                rb_sr_n = rb_word;
                rem_n   = rem - 1'b1;
                cnt_n   = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    rb_valid_n = 1'b1;
                    rb_data_n  = rb_word << pad;
                    if (rem == RW'(1)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n     = LOAD;
                        cfg_ready_n = 1'b1;
                    end
                end else begin
                    en_n   = 1'b1;
                    head_n = sr[WORD_W-1];
                    sr_n   = sr << 1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // state and registered outputs; reset aborts any shift without touching the chain
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state         <= IDLE;
            sr            <= '0;
            rb_sr         <= '0;
            rem           <= '0;
            cnt           <= '0;
            pad           <= '0;
            rb_data       <= '0;
            cfg_ready     <= 1'b0;
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
            rb_valid      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            sr            <= sr_n;
            rb_sr         <= rb_sr_n;
            rem           <= rem_n;
            cnt           <= cnt_n;
            pad           <= pad_n;
            rb_data       <= rb_data_n;
            cfg_ready     <= cfg_ready_n;
            ccff_head     <= head_n;
            config_enable <= en_n;
            rb_valid      <= rb_valid_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: scoreboard bench for ccff_chain_loader with behavioural chain models
module tb_ccff_chain_loader;
    localparam int W  = 32;
    localparam int L  = 41;
    localparam int LB = 64;

    logic         prog_clk = 1'b0;
    logic         pReset = 1'b1;
    logic         start = 1'b0, cfg_valid = 1'b0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_ready, ccff_head, config_enable, ccff_tail, rb_valid, busy, done;
    logic [W-1:0] rb_data;
    logic         start_b = 1'b0, cfg_valid_b = 1'b0;
    logic [W-1:0] cfg_data_b = '0;
    logic         cfg_ready_b, ccff_head_b, config_enable_b, ccff_tail_b, rb_valid_b, busy_b, done_b;
    logic [W-1:0] rb_data_b;

    int checks = 0, failures = 0, cyc = 0;

    logic [L-1:0]  chain, pre_val = '0;
    logic [LB-1:0] chain_b, pre_val_b = '0;
    logic          pre_en = 1'b0, pre_en_b = 1'b0;

    logic         hq[$], hq_b[$];
    logic [W-1:0] rq[$], rq_b[$];
    int           en_n = 0, runs = 0, rbv_n = 0, done_n = 0, done_cyc = 0;
    int           en_nb = 0, rbv_nb = 0, done_nb = 0, done_cyc_b = 0;
    logic         en_d = 1'b0;

    ccff_chain_loader dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
        .config_enable(config_enable), .ccff_tail(ccff_tail), .rb_data(rb_data),
        .rb_valid(rb_valid), .busy(busy), .done(done)
    );

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(LB)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .cfg_data(cfg_data_b),
        .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .ccff_head(ccff_head_b),
        .config_enable(config_enable_b), .ccff_tail(ccff_tail_b), .rb_data(rb_data_b),
        .rb_valid(rb_valid_b), .busy(busy_b), .done(done_b)
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) cyc <= cyc + 1;

    // chain models: head feeds bit 0, tail is the top bit
    always @(posedge prog_clk) begin
        if (pre_en) chain <= pre_val;
        else if (config_enable) chain <= {chain[L-2:0], ccff_head};
        if (pre_en_b) chain_b <= pre_val_b;
        else if (config_enable_b) chain_b <= {chain_b[LB-2:0], ccff_head_b};
    end
    assign ccff_tail   = chain[L-1];
    assign ccff_tail_b = chain_b[LB-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitors sample away from the active edge
    always @(negedge prog_clk) begin
        if (config_enable) begin
            en_n <= en_n + 1;
            if (!en_d) runs <= runs + 1;
            check("head_avail", 64'(hq.size() != 0), 64'(1));
            if (hq.size() != 0) check("ccff_head", 64'(ccff_head), 64'(hq.pop_front()));
        end
        en_d <= config_enable;
        if (rb_valid) begin
            rbv_n <= rbv_n + 1;
            check("rb_avail", 64'(rq.size() != 0), 64'(1));
            if (rq.size() != 0) check("rb_data", 64'(rb_data), 64'(rq.pop_front()));
        end
        if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
    end

    always @(negedge prog_clk) begin
        if (config_enable_b) begin
            en_nb <= en_nb + 1;
            check("b_head_avail", 64'(hq_b.size() != 0), 64'(1));
            if (hq_b.size() != 0) check("b_ccff_head", 64'(ccff_head_b), 64'(hq_b.pop_front()));
        end
        if (rb_valid_b) begin
            rbv_nb <= rbv_nb + 1;
            check("b_rb_avail", 64'(rq_b.size() != 0), 64'(1));
            if (rq_b.size() != 0) check("b_rb_data", 64'(rb_data_b), 64'(rq_b.pop_front()));
        end
        if (done_b) begin
            done_nb    <= done_nb + 1;
            done_cyc_b <= cyc;
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge prog_clk);
            if (cfg_ready) begin
                @(posedge prog_clk);
                #1;
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge prog_clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic preload(input logic [L-1:0] v);
        @(posedge prog_clk);
        #1;
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge prog_clk);
        #1;
        pre_en = 1'b0;
    endtask

    // one full 41-bit load; optional LOAD stall before the second word or stray start mid-shift
    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1, input int stall,
                           input bit poke, input int exp_len);
        int e0 = en_n, r0 = runs, v0 = rbv_n, d0 = done_n, c0;
        bit ok;
        rq.push_back(chain[L-1 -: W]);
        rq.push_back({chain[L-W-1:0], {(2*W-L){1'b0}}});
        for (int i = 0; i < W; i++) hq.push_back(w0[W-1-i]);
        for (int i = 0; i < L - W; i++) hq.push_back(w1[W-1-i]);
        @(posedge prog_clk);
        #1;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = w0;
        c0        = cyc;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        wait_ready(ok);
        check("accept_w0", 64'(ok), 64'(1));
        cfg_data  = w1;
        cfg_valid = (stall == 0);
        if (poke) begin
            repeat (3) @(posedge prog_clk);
            #1;
            start = 1'b1;
            @(posedge prog_clk);
            #1;
            start = 1'b0;
        end
        if (stall > 0) begin
            wait_ready(ok);
            repeat (stall - 1) @(posedge prog_clk);
            #1;
            cfg_valid = 1'b1;
        end
        wait_ready(ok);
        check("accept_w1", 64'(ok), 64'(1));
        cfg_valid = 1'b0;
        wait_idle(ok);
        check("back_to_idle", 64'(ok), 64'(1));
        check("enable_cycles", 64'(en_n - e0), 64'(L));
        check("enable_runs", 64'(runs - r0), 64'(2));
        check("rb_valid_pulses", 64'(rbv_n - v0), 64'(2));
        check("done_pulses", 64'(done_n - d0), 64'(1));
        check("done_cycle", 64'(done_cyc - c0 + 1), 64'(exp_len));
        check("chain_content", 64'(chain), 64'({w0, w1[W-1 -: L-W]}));
    endtask

    initial begin
        logic [L-1:0] alt, snap;
        logic [W-1:0] w0, w1;
        int           e0, v0, d0, c0;
        bit           ok;
        pre_en   = 1'b1;
        pre_en_b = 1'b1;
        repeat (3) @(posedge prog_clk);
        #1;
        pre_en   = 1'b0;
        pre_en_b = 1'b0;
        @(negedge prog_clk);
        check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
        check("rst_ccff_head", 64'(ccff_head), 64'(0));
        check("rst_config_enable", 64'(config_enable), 64'(0));
        check("rst_rb_valid", 64'(rb_valid), 64'(0));
        check("rst_rb_data", 64'(rb_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_b_busy", 64'({busy_b, cfg_ready_b, config_enable_b, done_b, rb_valid_b}), 64'(0));
        @(posedge prog_clk);
        #1;
        pReset = 1'b0;

        // default load into a cleared chain
        do_load(32'hA5A5A5A5, 32'hFF800000, 0, 1'b0, 45);

        // readback of a chain holding alternating 1,0 from the tail
        for (int i = 0; i < L; i++) alt[L-1-i] = (i % 2 == 0);
        preload(alt);
        do_load($urandom, $urandom, 0, 1'b0, 45);

        // five-cycle stall before the second word
        do_load($urandom, $urandom, 5, 1'b0, 50);

        // stray start during SHIFT
        do_load($urandom, $urandom, 0, 1'b1, 45);

        // reset on the 20th shift cycle, then reset colliding with start in IDLE
        w0 = $urandom;
        snap = chain;
        e0 = en_n; v0 = rbv_n; d0 = done_n;
        for (int i = 0; i < 20; i++) hq.push_back(w0[W-1-i]);
        @(posedge prog_clk);
        #1;
        start = 1'b1; cfg_valid = 1'b1; cfg_data = w0;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        wait_ready(ok);
        check("rst_accept", 64'(ok), 64'(1));
        cfg_valid = 1'b0;
        repeat (19) @(posedge prog_clk);
        #1;
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b1;
        @(negedge prog_clk);
        check("abort_outputs", 64'({cfg_ready, ccff_head, config_enable, rb_valid, busy, done}), 64'(0));
        check("abort_rb_data", 64'(rb_data), 64'(0));
        @(posedge prog_clk);
        #1;
        pReset = 1'b0;
        start  = 1'b0;
        @(negedge prog_clk);
        check("reset_beats_start", 64'({busy, cfg_ready}), 64'(0));
        check("abort_shifts", 64'(en_n - e0), 64'(20));
        check("abort_no_done", 64'(done_n - d0), 64'(0));
        check("abort_no_rb", 64'(rbv_n - v0), 64'(0));
        check("abort_head_q", 64'(hq.size()), 64'(0));
        check("abort_chain", 64'(chain), 64'({snap[L-21:0], w0[W-1 -: 20]}));
        do_load($urandom, $urandom, 0, 1'b0, 45);

        // 64-bit chain: two full words, no padding
        w0 = $urandom;
        w1 = $urandom;
        @(posedge prog_clk);
        #1;
        pre_val_b = {32'($urandom), 32'($urandom)};
        pre_en_b  = 1'b1;
        @(posedge prog_clk);
        #1;
        pre_en_b = 1'b0;
        rq_b.push_back(pre_val_b[LB-1 -: W]);
        rq_b.push_back(pre_val_b[W-1:0]);
        for (int i = 0; i < W; i++) hq_b.push_back(w0[W-1-i]);
        for (int i = 0; i < W; i++) hq_b.push_back(w1[W-1-i]);
        @(posedge prog_clk);
        #1;
        start_b = 1'b1; cfg_valid_b = 1'b1; cfg_data_b = w0;
        c0 = cyc;
        @(posedge prog_clk);
        #1;
        start_b = 1'b0;
        @(posedge prog_clk);
        #1;
        cfg_data_b = w1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge prog_clk);
            if (!busy_b) ok = 1'b1;
        end
        cfg_valid_b = 1'b0;
        check("b_idle", 64'(ok), 64'(1));
        check("b_enable_cycles", 64'(en_nb), 64'(LB));
        check("b_rb_valid_pulses", 64'(rbv_nb), 64'(2));
        check("b_done_pulses", 64'(done_nb), 64'(1));
        check("b_done_cycle", 64'(done_cyc_b - c0 + 1), 64'(68));
        check("b_chain_content", chain_b, {w0, w1});

        check("head_q_drained", 64'(hq.size()), 64'(0));
        check("rb_q_drained", 64'(rq.size()), 64'(0));
        check("b_queues_drained", 64'(hq_b.size() + rq_b.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
